// File: rtl/amba3_apb_if.sv
// AMBA3 APB bus bundle shared by the requester and the memory completer.
interface amba3_apb_if #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned DATA_SIZE = 32
) ();
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDR_SIZE-1:0] paddr;
    logic [DATA_SIZE-1:0] pwdata;
    logic [DATA_SIZE-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/amba3_apb_mem_slave.sv
// Word-addressed flop memory behind an AMBA3 APB completer port, with
// programmable wait states and an error response for bad addresses.
module amba3_apb_mem_slave #(
    parameter int unsigned          ADDR_SIZE   = 32,
    parameter int unsigned          DATA_SIZE   = 32,
    parameter int unsigned          DEPTH       = 64,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = '0,
    parameter int unsigned          WAIT_CYCLES = 0
) (
    input  logic        pclk,
    input  logic        preset_n,
    amba3_apb_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam logic [ADDR_SIZE:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_SIZE:0] ADDR_HI = ADDR_LO + (ADDR_SIZE+1)'(DEPTH * 4);

    // IDLE also covers the setup phase: the setup edge is taken from IDLE,
    // which lets a new transfer follow a completion with no idle cycle.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 err_q;
    logic                 wr_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [DATA_SIZE-1:0] prdata_q;
    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic                 setup_c;
    logic                 access_c;
    logic                 done_c;
    logic [ADDR_SIZE-1:0] offset_c;
    logic [IDX_W-1:0]     idx_c;
    logic                 err_c;

    // Address decode and phase qualifiers.
    always_comb begin
        setup_c  = (state == IDLE) && bus.psel && !bus.penable;
        access_c = (state == ACCESS) && bus.psel && bus.penable;
        done_c   = access_c && (wait_cnt == '0);
        offset_c = bus.paddr - BASE_ADDR;
        idx_c    = IDX_W'(offset_c >> 2);
        err_c    = (bus.paddr[1:0] != 2'b00)
                 | ({1'b0, bus.paddr} <  ADDR_LO)
                 | ({1'b0, bus.paddr} >= ADDR_HI);
    end

    // State register.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; leaving ACCESS early is a protocol abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (setup_c) state_nxt = ACCESS;
            ACCESS:  if (!access_c || done_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Response decode from registered state only.
    always_comb begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        if (state == ACCESS && wait_cnt == '0) begin
            bus.pready  = 1'b1;
            bus.pslverr = err_q;
        end
    end

    assign bus.prdata = prdata_q;

    // Request capture at setup, wait countdown and write commit at completion.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            prdata_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (setup_c) begin
            wr_q     <= bus.pwrite;
            idx_q    <= idx_c;
            wdata_q  <= bus.pwdata;
            wait_cnt <= CNT_W'(WAIT_CYCLES);
            err_q    <= err_c;
            if (!bus.pwrite) begin
                prdata_q <= err_c ? '0 : mem[idx_c];
            end
        end else if (access_c) begin
            if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end else if (wr_q && !err_q) begin
                mem[idx_q] <= wdata_q;
            end
        end
    end
endmodule

// File: tb/tb_amba3_apb_mem_slave.sv
// Directed bench for amba3_apb_mem_slave: one instance with no wait states
// and one with three, sharing the stimulus with a per-instance select.
module tb_amba3_apb_mem_slave;
    logic        pclk;
    logic        preset_n;
    logic        sel;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] rd;
    logic        rdy;
    logic        err;

    int n_checks;
    int n_fail;

    amba3_apb_if #(.ADDR_SIZE(32), .DATA_SIZE(32)) bus0 ();
    amba3_apb_if #(.ADDR_SIZE(32), .DATA_SIZE(32)) bus3 ();

    assign bus0.psel    = psel & ~sel;
    assign bus0.penable = penable;
    assign bus0.pwrite  = pwrite;
    assign bus0.paddr   = paddr;
    assign bus0.pwdata  = pwdata;
    assign bus3.psel    = psel & sel;
    assign bus3.penable = penable;
    assign bus3.pwrite  = pwrite;
    assign bus3.paddr   = paddr;
    assign bus3.pwdata  = pwdata;

    assign rd  = sel ? bus3.prdata  : bus0.prdata;
    assign rdy = sel ? bus3.pready  : bus0.pready;
    assign err = sel ? bus3.pslverr : bus0.pslverr;

    amba3_apb_mem_slave #(
        .ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)
    ) dut0 (
        .pclk(pclk), .preset_n(preset_n), .bus(bus0)
    );

    amba3_apb_mem_slave #(
        .ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)
    ) dut3 (
        .pclk(pclk), .preset_n(preset_n), .bus(bus3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full APB transfer; called at posedge+1, returns at posedge+1 after
    // the completion edge so consecutive calls run back-to-back.
    task automatic xfer(input logic s, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_wait,
                        input logic exp_err, input logic [31:0] exp_rd);
        int waits;
        sel     = s;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge pclk);
        check("setup_pready", 32'(rdy), 32'd0);
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr   = ~addr;
        pwdata  = ~data;
        pwrite  = ~wr;
        waits   = 0;
        forever begin
            @(negedge pclk);
            if (rdy) break;
            waits++;
            if (waits >= 32) break;
            @(posedge pclk); #1;
        end
        check("wait_states", 32'(waits), 32'(exp_wait));
        check("pslverr", 32'(err), 32'(exp_err));
        if (!wr) check("prdata", rd, exp_rd);
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        preset_n = 1'b0;
        sel      = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;

        // Reset state of both instances.
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_pready0",  32'(bus0.pready),  32'd0);
        check("rst_pslverr0", 32'(bus0.pslverr), 32'd0);
        check("rst_prdata0",  bus0.prdata,       32'd0);
        check("rst_pready3",  32'(bus3.pready),  32'd0);
        check("rst_pslverr3", 32'(bus3.pslverr), 32'd0);
        check("rst_prdata3",  bus3.prdata,       32'd0);
        @(posedge pclk); #1;
        preset_n = 1'b1;
        idle(2);

        // No wait states: writes then read-back.
        xfer(1'b0, 1'b1, 32'h00, 32'h0000_0004, 0, 1'b0, 32'h0);
        xfer(1'b0, 1'b1, 32'h04, 32'h0000_0008, 0, 1'b0, 32'h0);
        xfer(1'b0, 1'b1, 32'h10, 32'h0000_0014, 0, 1'b0, 32'h0);
        xfer(1'b0, 1'b1, 32'h18, 32'h0000_001C, 0, 1'b0, 32'h0);
        idle(1);
        xfer(1'b0, 1'b0, 32'h00, 32'h0, 0, 1'b0, 32'h0000_0004);
        xfer(1'b0, 1'b0, 32'h04, 32'h0, 0, 1'b0, 32'h0000_0008);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h0000_0014);
        xfer(1'b0, 1'b0, 32'h18, 32'h0, 0, 1'b0, 32'h0000_001C);
        xfer(1'b0, 1'b0, 32'h08, 32'h0, 0, 1'b0, 32'h0000_0000);
        idle(1);

        // Write immediately followed by a read of the same word.
        xfer(1'b0, 1'b1, 32'h88, 32'h2244_6688, 0, 1'b0, 32'h0);
        xfer(1'b0, 1'b0, 32'h88, 32'h0, 0, 1'b0, 32'h2244_6688);
        idle(1);

        // Error responses; both bad addresses alias onto word 0.
        xfer(1'b0, 1'b1, 32'h02,  32'hDEAD_BEEF, 0, 1'b1, 32'h0);
        xfer(1'b0, 1'b1, 32'h100, 32'h0000_0001, 0, 1'b1, 32'h0);
        xfer(1'b0, 1'b0, 32'h00,  32'h0, 0, 1'b0, 32'h0000_0004);
        xfer(1'b0, 1'b0, 32'h100, 32'h0, 0, 1'b1, 32'h0000_0000);
        xfer(1'b0, 1'b0, 32'hFC,  32'h0, 0, 1'b0, 32'h0000_0000);
        idle(1);

        // Three wait states.
        xfer(1'b1, 1'b1, 32'h40, 32'h1234_5678, 3, 1'b0, 32'h0);
        xfer(1'b1, 1'b0, 32'h40, 32'h0, 3, 1'b0, 32'h1234_5678);
        xfer(1'b1, 1'b1, 32'h08, 32'hA5A5_A5A5, 3, 1'b0, 32'h0);
        idle(1);

        // Abort a waited write to 0x8 by dropping psel.
        sel     = 1'b1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h08;
        pwdata  = 32'hFFFF_0000;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort_wait_pready", 32'(rdy), 32'd0);
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            check("abort_idle_pready", 32'(rdy), 32'd0);
        end
        @(posedge pclk); #1;
        xfer(1'b1, 1'b0, 32'h08, 32'h0, 3, 1'b0, 32'hA5A5_A5A5);
        xfer(1'b1, 1'b0, 32'h200, 32'h0, 3, 1'b1, 32'h0);
        idle(1);

        // Async reset in the middle of an access.
        sel     = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h00;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("pre_reset_pready", 32'(rdy), 32'd1);
        #2;
        preset_n = 1'b0;
        #1;
        check("reset_pready", 32'(rdy), 32'd0);
        check("reset_prdata", rd, 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        preset_n = 1'b1;
        idle(1);
        xfer(1'b0, 1'b0, 32'h00, 32'h0, 0, 1'b0, 32'h0000_0000);
        xfer(1'b0, 1'b0, 32'h88, 32'h0, 0, 1'b0, 32'h0000_0000);
        xfer(1'b1, 1'b0, 32'h40, 32'h0, 3, 1'b0, 32'h0000_0000);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
